eval_arbiter: RTL and testbench

- Shares one `evaluate` instance among NUM_REQ board requesters, such as parallel search or move-generation lanes.
- Grants round-robin and drives the evaluator's rising-edge `board_valid` / `clear_eval` handshake.
- Captures `eval` / `material` / `insufficient_material` and returns them to the granted requester with a one-cycle response pulse.
- Sits between the requesters and the evaluator plus its attack-map front end.

---
 rtl/eval_arbiter_pkg.sv | 18 +
 rtl/rr_arbiter_pick.sv | 35 +++
 rtl/eval_arbiter.sv | 143 ++++++++++++++
 tb/tb_eval_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eval_arbiter_pkg.sv
// Shared board width, state encodings and helpers for the evaluator arbiter.
// Optional watchdog in eval_arbiter is enabled by EVAL_ARB_TIMEOUT_EN.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 256
`endif

package eval_arbiter_pkg;

    localparam int BOARD_W = `BOARD_WIDTH;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_EVAL = 2'd2,
        DRAIN     = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin pick: first set request at or after rr, wrapping.
module rr_arbiter_pick #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any_req
);

    logic [NUM_REQ-1:0] rot;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        logic [IDX_W:0] s;
        s = {1'b0, base} + (IDX_W+1)'(off);
        if (s >= (IDX_W+1)'(NUM_REQ))
            s = s - (IDX_W+1)'(NUM_REQ);
        return s[IDX_W-1:0];
    endfunction

    // Rotate so bit 0 is the requester at rr; descending scan leaves the nearest hit.
    always_comb begin
        rot     = NUM_REQ'({req, req} >> rr);
        gnt_idx = '0;
        any_req = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                gnt_idx = wrap_add(rr, i);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eval_arbiter.sv
// Round-robin sharing of one evaluator among NUM_REQ requesters.
// Define EVAL_ARB_TIMEOUT_EN to add a WAIT_EVAL watchdog of TIMEOUT_CYCLES.
//
// state     | meaning
// IDLE      | no evaluation in flight; arbitrate and latch the winning board
// ISSUE     | board stable on ev_board; raise ev_board_valid next
// WAIT_EVAL | ev_board_valid high, waiting for ev_eval_valid (or watchdog)
// DRAIN     | result returned; wait for ev_eval_valid low before next issue
module eval_arbiter
    import eval_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int EVAL_WIDTH     = 24,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BOARD_W-1:0]   req_board,
    input  logic [NUM_REQ-1:0]           req_white_to_move,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic signed [EVAL_WIDTH-1:0] rsp_eval,
    output logic signed [31:0]           rsp_material,
    output logic                         rsp_insufficient,
    output logic                         rsp_timeout,
    output logic [BOARD_W-1:0]           ev_board,
    output logic                         ev_white_to_move,
    output logic                         ev_board_valid,
    output logic                         ev_clear_eval,
    input  logic                         ev_eval_valid,
    input  logic signed [EVAL_WIDTH-1:0] ev_eval,
    input  logic signed [31:0]           ev_material,
    input  logic                         ev_insufficient,
    output logic                         busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("eval_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
    end

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] rr, g, pick_idx;
    logic             any_req, grant, finish, timed_out;

    rr_arbiter_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (req),
        .rr      (rr),
        .gnt_idx (pick_idx),
        .any_req (any_req)
    );

`ifdef EVAL_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // Loaded in ISSUE so the terminal count lands on the TIMEOUT_CYCLES-th WAIT_EVAL cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            to_cnt <= '0;
        else if (state == ISSUE)
            to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
        else if (state == WAIT_EVAL && to_cnt != '0)
            to_cnt <= to_cnt - 1'b1;
    end

    assign timed_out = (state == WAIT_EVAL) && !ev_eval_valid && (to_cnt == '0);
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:     state_nxt = WAIT_EVAL;
            WAIT_EVAL: begin
                if (ev_eval_valid || timed_out) begin
                    finish    = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!ev_eval_valid)
                    state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr               <= '0;
            g                <= '0;
            ev_board         <= '0;
            ev_white_to_move <= 1'b0;
            rsp_valid        <= '0;
            ev_clear_eval    <= 1'b0;
            rsp_eval         <= '0;
            rsp_material     <= '0;
            rsp_insufficient <= 1'b0;
            rsp_timeout      <= 1'b0;
        end else begin
            rsp_valid     <= '0;
            ev_clear_eval <= 1'b0;
            if (grant) begin
                g                <= pick_idx;
                rr               <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                ev_board         <= req_board[pick_idx*BOARD_W +: BOARD_W];
                ev_white_to_move <= req_white_to_move[pick_idx];
            end
            if (finish) begin
                rsp_valid     <= NUM_REQ'(1) << g;
                ev_clear_eval <= 1'b1;
                rsp_timeout   <= timed_out;
                rsp_eval      <= timed_out ? '0 : ev_eval;
                if (!timed_out) begin
                    rsp_material     <= ev_material;
                    rsp_insufficient <= ev_insufficient;
                end
            end
        end
    end

    assign ev_board_valid = (state == WAIT_EVAL);
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_eval_arbiter.sv
// Directed self-checking bench for eval_arbiter (NUM_REQ=4, EVAL_WIDTH=24, TIMEOUT_CYCLES=15).
module tb_eval_arbiter;
    import eval_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int EW = 24;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [NR-1:0]          req;
    logic [NR*BOARD_W-1:0]  req_board;
    logic [NR-1:0]          req_white_to_move;
    logic [NR-1:0]          rsp_valid;
    logic signed [EW-1:0]   rsp_eval;
    logic signed [31:0]     rsp_material;
    logic                   rsp_insufficient;
    logic                   rsp_timeout;
    logic [BOARD_W-1:0]     ev_board;
    logic                   ev_white_to_move;
    logic                   ev_board_valid;
    logic                   ev_clear_eval;
    logic                   ev_eval_valid;
    logic signed [EW-1:0]   ev_eval;
    logic signed [31:0]     ev_material;
    logic                   ev_insufficient;
    logic                   busy;

    int errors = 0;
    int checks = 0;
    int bv_rise = 0;
    int rsp_pulses = 0;
    logic bv_prev = 1'b0;

    eval_arbiter #(.NUM_REQ(NR), .EVAL_WIDTH(EW), .TIMEOUT_CYCLES(15)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req               (req),
        .req_board         (req_board),
        .req_white_to_move (req_white_to_move),
        .rsp_valid         (rsp_valid),
        .rsp_eval          (rsp_eval),
        .rsp_material      (rsp_material),
        .rsp_insufficient  (rsp_insufficient),
        .rsp_timeout       (rsp_timeout),
        .ev_board          (ev_board),
        .ev_white_to_move  (ev_white_to_move),
        .ev_board_valid    (ev_board_valid),
        .ev_clear_eval     (ev_clear_eval),
        .ev_eval_valid     (ev_eval_valid),
        .ev_eval           (ev_eval),
        .ev_material       (ev_material),
        .ev_insufficient   (ev_insufficient),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ev_board_valid === 1'b1 && bv_prev === 1'b0) bv_rise++;
        if (rsp_valid != '0) rsp_pulses++;
        bv_prev = ev_board_valid;
    end

    function automatic logic [BOARD_W-1:0] mk_board(input int k);
        logic [31:0] w;
        w = 32'hC0FFEE00 ^ 32'(k);
        return {(BOARD_W/32){w}};
    endfunction

    task automatic wait_bv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ev_board_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic respond(input logic signed [EW-1:0] e, input logic signed [31:0] m, input logic ins);
        ev_eval         = e;
        ev_material     = m;
        ev_insufficient = ins;
        ev_eval_valid   = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, ev_board_valid, ev_clear_eval, rsp_valid, rsp_timeout, rsp_insufficient} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b bv=%b clr=%b rsp_valid=%b to=%b ins=%b required all 0",
                     busy, ev_board_valid, ev_clear_eval, rsp_valid, rsp_timeout, rsp_insufficient);
        end
        checks++;
        if (ev_board !== '0 || rsp_eval !== '0 || rsp_material !== '0 || ev_white_to_move !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: got eval=%0d mat=%0d wtm=%b board nonzero=%b required 0",
                     rsp_eval, rsp_material, ev_white_to_move, (ev_board != '0));
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_all_four;
        bit ok;
        int b0, p0;
        logic signed [EW-1:0] exp_e;
        b0 = bv_rise;
        p0 = rsp_pulses;
        req_white_to_move = 4'b0101;
        req = 4'b1111;
        @(negedge clk);
        for (int k = 0; k < NR; k++) begin
            wait_bv(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL all4_wait_bv[%0d]: got no ev_board_valid required high", k);
            end
            checks++;
            if (ev_board !== mk_board(k) || ev_white_to_move !== ((k % 2) == 0)) begin
                errors++;
                $display("FAIL all4_grant[%0d]: got board word %h wtm=%b required %h wtm=%b",
                         k, ev_board[31:0], ev_white_to_move, mk_board(k) >> 0, ((k % 2) == 0));
            end
            exp_e = EW'(k * 100 + 1);
            respond(exp_e, 32'(k), 1'b0);
            checks++;
            if (rsp_valid !== (4'b0001 << k) || rsp_eval !== exp_e) begin
                errors++;
                $display("FAIL all4_rsp[%0d]: got rsp_valid=%b eval=%0d required %b eval=%0d",
                         k, rsp_valid, rsp_eval, (4'b0001 << k), exp_e);
            end
            req[k] = 1'b0;
            @(negedge clk);
            ev_eval_valid = 1'b0;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bv_rise - b0 != 4 || rsp_pulses - p0 != 4) begin
            errors++;
            $display("FAIL all4_counts: got bv_rises=%0d rsp_pulses=%0d required 4 and 4",
                     bv_rise - b0, rsp_pulses - p0);
        end
        req = 4'b1001;
        @(negedge clk);
        wait_bv(ok);
        checks++;
        if (!ok || ev_board !== mk_board(0)) begin
            errors++;
            $display("FAIL all4_rr_wrap: got ok=%b board word %h required requester 0 word %h",
                     ok, ev_board[31:0], 32'hC0FFEE00);
        end
        respond(24'sd5, 32'sd0, 1'b0);
        req = 4'b0000;
        @(negedge clk);
        ev_eval_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        req_white_to_move = 4'b0010;
        req = 4'b0010;
        @(negedge clk);
        checks++;
        if (ev_board !== mk_board(1) || ev_board_valid !== 1'b0 || busy !== 1'b1 || ev_white_to_move !== 1'b1) begin
            errors++;
            $display("FAIL single_issue: got board word %h bv=%b busy=%b wtm=%b required %h 0 1 1",
                     ev_board[31:0], ev_board_valid, busy, ev_white_to_move, 32'hC0FFEE01);
        end
        @(negedge clk);
        checks++;
        if (ev_board_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_bv_latency: got bv=%b two cycles after req required 1", ev_board_valid);
        end
        respond(24'sd35, 32'sd120, 1'b0);
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_eval !== 24'sd35 || rsp_material !== 32'sd120 ||
            ev_clear_eval !== 1'b1 || ev_board_valid !== 1'b0 || rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: got rsp_valid=%b eval=%0d mat=%0d clr=%b bv=%b to=%b required 0010 35 120 1 0 0",
                     rsp_valid, rsp_eval, rsp_material, ev_clear_eval, ev_board_valid, rsp_timeout);
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0000 || ev_clear_eval !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_pulse_width: got rsp_valid=%b clr=%b busy=%b required 0000 0 1",
                     rsp_valid, ev_clear_eval, busy);
        end
        ev_eval_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_eval !== 24'sd35) begin
            errors++;
            $display("FAIL single_idle_hold: got busy=%b eval=%0d required 0 35", busy, rsp_eval);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        req = 4'b0100;
        @(negedge clk);
        wait_bv(ok);
        checks++;
        if (!ok || ev_board !== mk_board(2)) begin
            errors++;
            $display("FAIL b2b_first_issue: got ok=%b board word %h required %h", ok, ev_board[31:0], 32'hC0FFEE02);
        end
        respond(24'sd7, 32'sd1, 1'b0);
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_eval !== 24'sd7) begin
            errors++;
            $display("FAIL b2b_first_rsp: got rsp_valid=%b eval=%0d required 0100 7", rsp_valid, rsp_eval);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ev_board_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain_hold: got busy=%b bv=%b required 1 0", busy, ev_board_valid);
        end
        ev_eval_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ev_board_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: got busy=%b bv=%b required 0 0", busy, ev_board_valid);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ev_board_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reissue: got busy=%b bv=%b required 1 0", busy, ev_board_valid);
        end
        @(negedge clk);
        checks++;
        if (ev_board_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_bv: got bv=%b required 1", ev_board_valid);
        end
        respond(24'sd8, 32'sd2, 1'b0);
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_eval !== 24'sd8) begin
            errors++;
            $display("FAIL b2b_second_rsp: got rsp_valid=%b eval=%0d required 0100 8", rsp_valid, rsp_eval);
        end
        req = 4'b0000;
        @(negedge clk);
        ev_eval_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

`ifdef EVAL_ARB_TIMEOUT_EN
    task automatic test_timeout;
        bit ok;
        int n;
        req = 4'b0001;
        ev_eval_valid = 1'b0;
        @(negedge clk);
        wait_bv(ok);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid != '0) break;
            if (ev_board_valid === 1'b1) n++;
            @(negedge clk);
        end
        checks++;
        if (n != 15) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d WAIT_EVAL cycles required 15", n);
        end
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_timeout !== 1'b1 || rsp_eval !== '0 || ev_clear_eval !== 1'b1) begin
            errors++;
            $display("FAIL timeout_rsp: got rsp_valid=%b to=%b eval=%0d clr=%b required 0001 1 0 1",
                     rsp_valid, rsp_timeout, rsp_eval, ev_clear_eval);
        end
        req = 4'b0000;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: got busy=%b required 0", busy);
        end
    endtask
`endif

    task automatic test_negative;
        bit ok;
        req_white_to_move = 4'b0111;
        req = 4'b1000;
        @(negedge clk);
        wait_bv(ok);
        checks++;
        if (!ok || ev_board !== mk_board(3) || ev_white_to_move !== 1'b0) begin
            errors++;
            $display("FAIL neg_issue: got ok=%b board word %h wtm=%b required %h 0",
                     ok, ev_board[31:0], ev_white_to_move, 32'hC0FFEE03);
        end
        respond(-24'sd1200, -32'sd900, 1'b1);
        checks++;
        if (rsp_valid !== 4'b1000 || rsp_eval !== -24'sd1200 || rsp_material !== -32'sd900 ||
            rsp_insufficient !== 1'b1 || rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL neg_rsp: got rsp_valid=%b eval=%0d mat=%0d ins=%b to=%b required 1000 -1200 -900 1 0",
                     rsp_valid, rsp_eval, rsp_material, rsp_insufficient, rsp_timeout);
        end
        req = 4'b0000;
        @(negedge clk);
        ev_eval_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_eval !== -24'sd1200 || rsp_material !== -32'sd900 || rsp_insufficient !== 1'b1) begin
            errors++;
            $display("FAIL neg_hold: got eval=%0d mat=%0d ins=%b required -1200 -900 1",
                     rsp_eval, rsp_material, rsp_insufficient);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int p0;
        req = 4'b0011;
        @(negedge clk);
        wait_bv(ok);
        checks++;
        if (!ok || ev_board !== mk_board(0)) begin
            errors++;
            $display("FAIL rstmid_first_grant: got ok=%b board word %h required %h", ok, ev_board[31:0], 32'hC0FFEE00);
        end
        p0 = rsp_pulses;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, ev_board_valid, ev_clear_eval, rsp_valid, ev_white_to_move} !== '0 || ev_board !== '0) begin
            errors++;
            $display("FAIL rstmid_async_ctrl: got busy=%b bv=%b clr=%b rsp_valid=%b wtm=%b board nonzero=%b required all 0",
                     busy, ev_board_valid, ev_clear_eval, rsp_valid, ev_white_to_move, (ev_board != '0));
        end
        checks++;
        if (rsp_eval !== '0 || rsp_material !== '0 || rsp_insufficient !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async_data: got eval=%0d mat=%0d ins=%b required 0 0 0",
                     rsp_eval, rsp_material, rsp_insufficient);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        wait_bv(ok);
        checks++;
        if (!ok || ev_board !== mk_board(0) || rsp_pulses != p0) begin
            errors++;
            $display("FAIL rstmid_restart_rr0: got ok=%b board word %h extra pulses=%0d required %h and 0",
                     ok, ev_board[31:0], rsp_pulses - p0, 32'hC0FFEE00);
        end
        respond(24'sd9, 32'sd3, 1'b0);
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_eval !== 24'sd9) begin
            errors++;
            $display("FAIL rstmid_rsp: got rsp_valid=%b eval=%0d required 0001 9", rsp_valid, rsp_eval);
        end
        req = 4'b0000;
        @(negedge clk);
        ev_eval_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset_n           = 1'b0;
        req               = '0;
        req_white_to_move = '0;
        ev_eval_valid     = 1'b0;
        ev_eval           = '0;
        ev_material       = '0;
        ev_insufficient   = 1'b0;
        for (int k = 0; k < NR; k++)
            req_board[k*BOARD_W +: BOARD_W] = mk_board(k);
        @(negedge clk);
        test_reset;
        test_all_four;
        test_single;
        test_back_to_back;
`ifdef EVAL_ARB_TIMEOUT_EN
        test_timeout;
`endif
        test_negative;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no finish by 200000 required earlier finish");
        $fatal(1, "time limit");
    end

endmodule
